error_report_ctrl: RTL and testbench



---
 rtl/error_report_if.sv | 18 +
 rtl/error_report_ctrl.sv | 175 +++++++++++++++++
 tb/tb_error_report_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/error_report_if.sv
// Per-channel error update bus between the report scheduler and the error latch bank.
// The master drives the reported value and its one-hot single-cycle capture strobe.
interface error_report_if #(
    parameter int NCH = 18
);
    logic [NCH-1:0] err_in;
    logic [NCH-1:0] send_err;

    modport master (
        output err_in,
        output send_err
    );

    modport slave (
        input err_in,
        input send_err
    );
endinterface

// File: rtl/error_report_ctrl.sv
// Round-robin scheduler that pushes stale per-channel error levels to the latch bank,
// one strobe at a time with a fixed hold-off and an optional periodic full refresh.
module error_report_ctrl #(
    parameter int NCH            = 18,
    parameter int HOLD_CYCLES    = 4,
    parameter int REFRESH_PERIOD = 65535,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NCH-1:0]   err_raw,
    error_report_if.master   err_bus,
    output logic             busy,
    output logic [CNT_W-1:0] sent_count
);

    localparam int PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HOLD_W = 8;
    localparam int RC_W   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [NCH-1:0]     sync_reg;
    logic [NCH-1:0]     err_in_reg, err_in_next;
    logic [NCH-1:0]     send_err_reg, send_err_next;
    logic [NCH-1:0]     refresh_req_reg, refresh_req_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next, ptr_inc;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [CNT_W-1:0]   sent_count_reg, sent_count_next;
    logic [NCH-1:0]     pending;
    logic [NCH-1:0]     ptr_onehot;
    logic               pending_at_ptr;
    logic               do_send;
    logic               refresh_tick;

    // A channel is stale when the sampled level differs from what was last reported.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign pending[gi]    = (sync_reg[gi] ^ err_in_reg[gi]) | refresh_req_reg[gi];
            assign ptr_onehot[gi] = (ptr_reg == PTR_W'(gi));
        end
    endgenerate

    assign pending_at_ptr = |(pending & ptr_onehot);
    assign ptr_inc        = (ptr_reg == PTR_W'(NCH - 1)) ? '0 : ptr_reg + 1'b1;

    generate
        if (REFRESH_PERIOD > 0) begin : g_refresh
            logic [RC_W-1:0] refresh_cnt_reg;
            logic            refresh_wrap;

            assign refresh_wrap = (refresh_cnt_reg == RC_W'(REFRESH_PERIOD - 1));
            assign refresh_tick = enable & refresh_wrap;

            always_ff @(posedge clk) begin
                if (reset) begin
                    refresh_cnt_reg <= '0;
                end else if (enable) begin
                    refresh_cnt_reg <= refresh_wrap ? '0 : refresh_cnt_reg + 1'b1;
                end
            end
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (pending_at_ptr) begin
                    state_next = SEND;
                end
            end
            SEND: state_next = HOLD;
            HOLD: begin
                // Hold-off runs to completion regardless of enable.
                if (hold_reg <= HOLD_W'(1)) begin
                    state_next = enable ? SCAN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ptr_next  = ptr_reg;
        hold_next = hold_reg;
        do_send   = 1'b0;
        case (state_reg)
            SCAN: begin
                if (enable && !pending_at_ptr) begin
                    ptr_next = ptr_inc;
                end
            end
            SEND: begin
                do_send   = 1'b1;
                ptr_next  = ptr_inc;
                hold_next = HOLD_W'(HOLD_CYCLES);
            end
            HOLD: begin
                if (hold_reg != '0) begin
                    hold_next = hold_reg - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The served bit is cleared after the tick is applied, so a same-cycle refresh
    // of the channel being sent does not cause an immediate repeat.
    always_comb begin
        err_in_next      = err_in_reg;
        send_err_next    = '0;
        refresh_req_next = refresh_tick ? '1 : refresh_req_reg;
        sent_count_next  = sent_count_reg;
        if (do_send) begin
            err_in_next      = (err_in_reg & ~ptr_onehot) | (sync_reg & ptr_onehot);
            send_err_next    = ptr_onehot;
            refresh_req_next = refresh_req_next & ~ptr_onehot;
            if (sent_count_reg != '1) begin
                sent_count_next = sent_count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg        <= '0;
            err_in_reg      <= '0;
            send_err_reg    <= '0;
            refresh_req_reg <= '0;
            ptr_reg         <= '0;
            hold_reg        <= '0;
            sent_count_reg  <= '0;
        end else begin
            sync_reg        <= err_raw;
            err_in_reg      <= err_in_next;
            send_err_reg    <= send_err_next;
            refresh_req_reg <= refresh_req_next;
            ptr_reg         <= ptr_next;
            hold_reg        <= hold_next;
            sent_count_reg  <= sent_count_next;
        end
    end

    assign err_bus.err_in   = err_in_reg;
    assign err_bus.send_err = send_err_reg;
    assign sent_count       = sent_count_reg;
    assign busy             = (state_reg != IDLE) | (|pending);

endmodule

// File: tb/tb_error_report_ctrl.sv
// Directed bench for error_report_ctrl: a non-refresh instance for scheduling tests
// and a short-period refresh instance for the periodic re-send behaviour.
module tb_error_report_ctrl;

    localparam int NCH  = 18;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic [NCH-1:0] err_raw = '0;
    logic           busy;
    logic [15:0]    sent_count;

    logic           reset_r = 1'b1;
    logic           enable_r = 1'b0;
    logic [NCH-1:0] err_raw_r = 18'h00401;
    logic           busy_r;
    logic [15:0]    sent_count_r;

    error_report_if #(.NCH(NCH)) bus ();
    error_report_if #(.NCH(NCH)) bus_r ();

    error_report_ctrl #(
        .NCH(NCH), .HOLD_CYCLES(HOLD), .REFRESH_PERIOD(0), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .err_raw(err_raw),
        .err_bus(bus), .busy(busy), .sent_count(sent_count)
    );

    error_report_ctrl #(
        .NCH(NCH), .HOLD_CYCLES(1), .REFRESH_PERIOD(100), .CNT_W(16)
    ) dut_r (
        .clk(clk), .reset(reset_r), .enable(enable_r), .err_raw(err_raw_r),
        .err_bus(bus_r), .busy(busy_r), .sent_count(sent_count_r)
    );

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    logic [NCH-1:0] prev_se   = '0;
    logic [NCH-1:0] prev_se_r = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe rules: at most one bit, never on back-to-back cycles.
    always @(negedge clk) begin
        if (!$onehot0(bus.send_err)) viol++;
        if ((|prev_se) && (|bus.send_err)) viol++;
        if (!$onehot0(bus_r.send_err)) viol++;
        if ((|prev_se_r) && (|bus_r.send_err)) viol++;
        prev_se   = bus.send_err;
        prev_se_r = bus_r.send_err;
        if (|bus.send_err)
            $display("t=%0t strobe send_err=%05h err_in=%05h sent_count=%0d",
                     $time, bus.send_err, bus.err_in, sent_count);
    end

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        err_raw = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input int max_cyc, output int lat, output logic [NCH-1:0] se);
        lat = 0;
        se  = '0;
        while (lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (|bus.send_err) begin
                se = bus.send_err;
                return;
            end
        end
        lat = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int c0;
        int bad;
        logic [NCH-1:0] se;

        // Reset state
        do_reset();
        check("rst_err_in", 32'(bus.err_in), 32'h0);
        check("rst_send_err", 32'(bus.send_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(sent_count), 32'h0);

        // Nothing stale: scheduler scans but never strobes
        enable = 1'b1;
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (|bus.send_err) n++;
        end
        check("quiet_strobes", n, 0);
        check("quiet_count", 32'(sent_count), 32'h0);
        check("quiet_busy_scan", 32'(busy), 32'h1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("quiet_busy_idle", 32'(busy), 32'h0);
        $display("txn quiet: strobes=%0d sent_count=%0d", n, sent_count);

        // Single channel rise with scan starting at ch0: 5 scan steps + sync + SEND + out
        do_reset();
        enable  = 1'b1;
        err_raw = 18'h00020;
        wait_strobe(40, lat, se);
        check("ch5_latency", lat, 8);
        check("ch5_strobe", 32'(se), 32'h00020);
        check("ch5_err_in", 32'(bus.err_in), 32'h00020);
        check("ch5_count", 32'(sent_count), 32'h1);
        @(negedge clk);
        check("ch5_pulse_width", 32'(bus.send_err), 32'h0);
        $display("txn ch5: latency=%0d strobe=%05h", lat, se);

        // All channels pending: strict order and hold-off spacing
        do_reset();
        enable  = 1'b1;
        err_raw = '1;
        for (int i = 0; i < NCH; i++) begin
            wait_strobe(40, lat, se);
            check($sformatf("all_ch%0d", i), 32'(se), 32'(1) << i);
            check($sformatf("all_gap%0d", i), lat, (i == 0) ? 3 : HOLD + 2);
        end
        check("all_err_in", 32'(bus.err_in), 32'h3FFFF);
        check("all_count", 32'(sent_count), 32'd18);
        $display("txn all: err_in=%05h sent_count=%0d", bus.err_in, sent_count);

        // Glitch on ch3 while ch2 is in hold-off must be forgotten
        do_reset();
        enable  = 1'b1;
        err_raw = 18'h00004;
        wait_strobe(40, lat, se);
        check("glitch_ch2_latency", lat, 5);
        check("glitch_ch2_strobe", 32'(se), 32'h00004);
        err_raw = 18'h0000C;
        @(negedge clk);
        err_raw = 18'h00004;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.send_err[3]) n++;
        end
        check("glitch_ch3_strobes", n, 0);
        check("glitch_ch3_err_in", 32'(bus.err_in[3]), 32'h0);
        check("glitch_count", 32'(sent_count), 32'h1);
        $display("txn glitch: ch3_strobes=%0d err_in=%05h", n, bus.err_in);

        // Reset lands while ch9 is in SEND
        do_reset();
        enable  = 1'b1;
        err_raw = 18'h00200;
        repeat (11) @(negedge clk);
        check("rst_mid_pre", 32'(bus.send_err), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_send_err", 32'(bus.send_err), 32'h0);
        check("rst_mid_err_in", 32'(bus.err_in), 32'h0);
        check("rst_mid_count", 32'(sent_count), 32'h0);
        reset   = 1'b0;
        err_raw = 18'h00210;
        wait_strobe(40, lat, se);
        check("rst_after_first", 32'(se), 32'h00010);
        check("rst_after_latency", lat, 7);
        wait_strobe(40, lat, se);
        check("rst_after_second", 32'(se), 32'h00200);
        $display("txn reset_mid: err_in=%05h sent_count=%0d", bus.err_in, sent_count);

        // Periodic refresh: any 100-cycle window in steady state holds 18 strobes
        reset_r  = 1'b0;
        enable_r = 1'b1;
        repeat (150) @(negedge clk);
        c0  = int'(sent_count_r);
        n   = 0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (|bus_r.send_err) n++;
            if (bus_r.err_in !== 18'h00401) bad++;
        end
        check("refresh_strobes", n, 18);
        check("refresh_count_delta", int'(sent_count_r) - c0, 18);
        check("refresh_err_in_stable", bad, 0);
        check("refresh_err_in", 32'(bus_r.err_in), 32'h00401);
        $display("txn refresh: strobes=%0d sent_count=%0d", n, sent_count_r);

        check("strobe_rules", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
